// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: iterative controller for one AES encryption round.
// It runs SubBytes one byte per cycle through a single shared S-box, then
// ShiftRows in one cycle, then MixColumns one column per cycle through a
// shared column mixer, and finally AddRoundKey.
// State layout: byte i = st[8*i +: 8]. Element (row r, column c) is byte
// 4*r + c. Column c is therefore {byte c+12, byte c+8, byte c+4, byte c}.
// Build option: define AES_SEQ_DUAL_SBOX_EN to use two S-boxes, which
// substitutes bytes 2k and 2k+1 together and finishes SubBytes in 8 cycles.
module aes_round_sequencer (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] state_in,
   input  logic [127:0] round_key,
   input  logic         final_round,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] state_out,
   output logic         busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SUB,
      S_SHIFT,
      S_MIX,
      S_ARK,
      S_DONE
   } state_t;

   // Forward S-box. Entry 0 is the leftmost byte of the first row.
   localparam logic [0:255][7:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

`ifdef AES_SEQ_DUAL_SBOX_EN
   localparam logic [3:0] BC_STEP = 4'd2;
   localparam logic [3:0] BC_LAST = 4'd14;
`else
   localparam logic [3:0] BC_STEP = 4'd1;
   localparam logic [3:0] BC_LAST = 4'd15;
`endif

   state_t        r_state;
   state_t        w_state_nxt;
   logic [127:0]  r_st;
   logic [127:0]  r_key_q;
   logic          r_fin_q;
   logic [3:0]    r_bc;
   logic [1:0]    r_cc;

   logic [7:0]    w_sb_in0;
   logic [7:0]    w_sb_out0;
`ifdef AES_SEQ_DUAL_SBOX_EN
   logic [3:0]    w_bc_odd;
   logic [7:0]    w_sb_in1;
   logic [7:0]    w_sb_out1;
`endif
   logic [31:0]   w_col;
   logic [31:0]   w_mix;
   logic [127:0]  w_shifted;

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TABLE[b];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Column word carries row r in bits [8*r +: 8].
   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a3, a2, a1, a0} = col;
      return {xtime(a3) ^ xtime(a0) ^ a0 ^ a1 ^ a2,
              xtime(a2) ^ xtime(a3) ^ a3 ^ a0 ^ a1,
              xtime(a1) ^ xtime(a2) ^ a2 ^ a3 ^ a0,
              xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3};
   endfunction

   // Row r is rotated left by r positions.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            o[8*(4*r + c) +: 8] = s[8*(4*r + ((c + r) % 4)) +: 8];
         end
      end
      return o;
   endfunction

   // Shared datapath: each S-box and the column mixer has a single call site.
   assign w_sb_in0  = r_st[8*r_bc +: 8];
   assign w_sb_out0 = sbox(w_sb_in0);
`ifdef AES_SEQ_DUAL_SBOX_EN
   assign w_bc_odd  = {r_bc[3:1], 1'b1};
   assign w_sb_in1  = r_st[8*w_bc_odd +: 8];
   assign w_sb_out1 = sbox(w_sb_in1);
`endif
   assign w_col     = {r_st[96 + 8*r_cc +: 8], r_st[64 + 8*r_cc +: 8],
                       r_st[32 + 8*r_cc +: 8], r_st[8*r_cc +: 8]};
   assign w_mix     = mix_column(w_col);
   assign w_shifted = shift_rows(r_st);
   assign state_out = r_st;

   // State register; reset wins over any handshake in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and handshake outputs.
   always_comb begin
      // NOTE: every output gets a default before the case so that no path leaves it unassigned, which would infer a latch.
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b1;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) w_state_nxt = S_SUB;
         end
         S_SUB:   if (r_bc == BC_LAST) w_state_nxt = S_SHIFT;
         S_SHIFT: w_state_nxt = r_fin_q ? S_ARK : S_MIX;
         S_MIX:   if (r_cc == 2'd3) w_state_nxt = S_ARK;
         S_ARK:   w_state_nxt = S_DONE;
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Round datapath: capture, per-byte substitution, permutation, per-column mix, key add.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         r_st    <= '0;
         r_key_q <= '0;
         r_fin_q <= 1'b0;
         r_bc    <= '0;
         r_cc    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_st    <= state_in;
                  r_key_q <= round_key;
                  r_fin_q <= final_round;
                  r_bc    <= '0;
               end
            end
            S_SUB: begin
               r_st[8*r_bc +: 8] <= w_sb_out0;
`ifdef AES_SEQ_DUAL_SBOX_EN
               r_st[8*w_bc_odd +: 8] <= w_sb_out1;
`endif
               r_bc <= r_bc + BC_STEP;
            end
            S_SHIFT: begin
               r_st <= w_shifted;
               if (!r_fin_q) r_cc <= '0;
            end
            S_MIX: begin
               r_st[8*r_cc +: 8]      <= w_mix[7:0];
               r_st[32 + 8*r_cc +: 8] <= w_mix[15:8];
               r_st[64 + 8*r_cc +: 8] <= w_mix[23:16];
               r_st[96 + 8*r_cc +: 8] <= w_mix[31:24];
               r_cc <= r_cc + 2'd1;
            end
            S_ARK: r_st <= r_st ^ r_key_q;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer. The reference model works on a
// 4x4 byte matrix (element r,c = byte 4r+c) and derives the S-box from GF(2^8)
// inversion plus the affine map, so it shares no tables with the design.
// Honours AES_SEQ_DUAL_SBOX_EN for the expected latencies.
module tb_aes_round_sequencer;

`ifdef AES_SEQ_DUAL_SBOX_EN
   localparam int LAT_FULL  = 15;
   localparam int LAT_FINAL = 11;
`else
   localparam int LAT_FULL  = 23;
   localparam int LAT_FINAL = 19;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         final_round = 1'b0;
   logic         out_ready = 1'b0;
   logic [127:0] state_in = '0;
   logic [127:0] round_key = '0;
   logic         in_ready;
   logic         out_valid;
   logic         busy;
   logic [127:0] state_out;

   int           vectors = 0;
   int           miscompares = 0;
   logic [7:0]   sb_model [256];

   always #5 clk = ~clk;

   aes_round_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .state_in    (state_in),
      .round_key   (round_key),
      .final_round (final_round),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .state_out   (state_out),
      .busy        (busy)
   );

   task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      return 8'((b << n) | (b >> (8 - n)));
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         sb_model[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] round_model(input logic [127:0] s, input logic [127:0] k, input logic fin);
      logic [7:0]   m [4][4];
      logic [7:0]   t [4][4];
      logic [127:0] o;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            m[r][c] = sb_model[s[8*(4*r + c) +: 8]];
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            t[r][c] = m[r][(c + r) % 4];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            m[r][c] = fin ? t[r][c]
                          : gmul(t[r][c], 8'h02) ^ gmul(t[(r + 1) % 4][c], 8'h03)
                            ^ t[(r + 2) % 4][c] ^ t[(r + 3) % 4][c];
      o = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            o[8*(4*r + c) +: 8] = m[r][c] ^ k[8*(4*r + c) +: 8];
      return o;
   endfunction

   // Human-readable matrix hex (row 0 first, leftmost) to the port byte order.
   function automatic logic [127:0] pack_rows(input logic [127:0] h);
      logic [127:0] o;
      for (int k = 0; k < 16; k++) o[8*k +: 8] = h[8*(15 - k) +: 8];
      return o;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // All tasks below start and end at a falling edge.
   task automatic start(input logic [127:0] s, input logic [127:0] k, input logic fin, input string tag);
      int n;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({tag, " in_ready before request"}, 128'(in_ready), 128'(1));
      state_in    = s;
      round_key   = k;
      final_round = fin;
      in_valid    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid    = 1'b0;
   endtask

   task automatic wait_done(input string tag, output int lat);
      int k;
      k = 0;
      while (!out_valid && k < 200) begin
         @(posedge clk);
         k++;
         @(negedge clk);
      end
      lat = k + 1;
      check({tag, " out_valid reached"}, 128'(out_valid), 128'(1));
      check({tag, " in_ready low in DONE"}, 128'(in_ready), 128'(0));
   endtask

   task automatic release_result(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, " out_valid after handshake"}, 128'(out_valid), 128'(0));
      check({tag, " in_ready after handshake"}, 128'(in_ready), 128'(1));
   endtask

   task automatic run_round(input logic [127:0] s, input logic [127:0] k, input logic fin,
                            input string tag, output logic [127:0] res);
      int lat;
      start(s, k, fin, tag);
      wait_done(tag, lat);
      check({tag, " latency"}, 128'(lat), 128'(fin ? LAT_FINAL : LAT_FULL));
      res = state_out;
      check({tag, " result vs model"}, res, round_model(s, k, fin));
      release_result(tag);
   endtask

   task automatic back_to_back(input logic fin, input int nacc, input string tag);
      logic [127:0] exp_q [$];
      int           acc_t [$];
      int           cyc;
      int           acc;
      logic         accepting;
      cyc = 0;
      acc = 0;
      out_ready   = 1'b1;
      final_round = fin;
      state_in    = rand128();
      round_key   = rand128();
      in_valid    = 1'b1;
      while ((acc < nacc || exp_q.size() > 0) && cyc < 2000) begin
         if (out_valid) begin
            if (exp_q.size() == 0) check({tag, " unexpected result"}, 128'(out_valid), 128'(0));
            else check({tag, " result"}, state_out, exp_q.pop_front());
         end
         accepting = in_ready && in_valid;
         if (accepting) begin
            exp_q.push_back(round_model(state_in, round_key, fin));
            acc_t.push_back(cyc);
            acc++;
         end
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (accepting) begin
            if (acc == nacc) begin
               in_valid = 1'b0;
            end else begin
               state_in  = rand128();
               round_key = rand128();
            end
         end
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check({tag, " acceptances"}, 128'(acc), 128'(nacc));
      check({tag, " results outstanding"}, 128'(exp_q.size()), 128'(0));
      for (int i = 1; i < acc_t.size(); i++)
         check({tag, " acceptance spacing"}, 128'(acc_t[i] - acc_t[i-1]),
               128'((fin ? LAT_FINAL : LAT_FULL) + 1));
   endtask

   initial begin
      logic [127:0] res;
      logic [127:0] cap;
      logic [127:0] s_fips;
      int           lat;

      build_sbox();

      // Reset, with a request presented during reset that must be ignored.
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      state_in  = rand128();
      round_key = rand128();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset in_ready", 128'(in_ready), 128'(1));
      check("reset out_valid", 128'(out_valid), 128'(0));
      check("reset busy", 128'(busy), 128'(0));
      check("reset state_out", state_out, 128'(0));
      in_valid = 1'b0;
      rst_n    = 1'b1;
      @(negedge clk);

      // Directed vectors with closed-form results.
      run_round('0, '0, 1'b1, "zero final", res);
      check("zero final const", res, {16{8'h63}});
      run_round('0, {16{8'hff}}, 1'b0, "zero keyff", res);
      check("zero keyff const", res, {16{8'h9c}});
      run_round({16{8'h53}}, '0, 1'b0, "x53", res);
      check("x53 const", res, {16{8'hed}});

      // Round 1 of the FIPS-197 example; column 0 after MixColumns is d4bf5d30 -> 046681e5.
      s_fips = pack_rows(128'h19a09ae9_3df4c6f8_e3e28d48_be2b2a08);
      run_round(s_fips, pack_rows(128'ha088232a_fa54a36c_fe2c3976_17b13905), 1'b0, "fips", res);
      check("fips const", res, pack_rows(128'ha4686b02_9c9f5b6a_7f35ea50_f22b4349));
      run_round(s_fips, '0, 1'b0, "fips col", res);
      check("fips column 0", 128'({res[7:0], res[39:32], res[71:64], res[103:96]}), 128'(32'h046681e5));

      // Backpressure: result held for 10 cycles while in_valid pulses are ignored.
      s_fips = rand128();
      cap    = rand128();
      start(s_fips, cap, 1'b0, "bp");
      wait_done("bp", lat);
      res = state_out;
      check("bp result vs model", res, round_model(s_fips, cap, 1'b0));
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0];
         state_in = rand128();
         @(posedge clk);
         @(negedge clk);
         check("bp out_valid held", 128'(out_valid), 128'(1));
         check("bp state_out held", state_out, res);
         check("bp in_ready low", 128'(in_ready), 128'(0));
      end
      in_valid = 1'b0;
      release_result("bp");
      repeat (2) @(negedge clk);
      check("bp nothing queued", 128'(busy), 128'(0));

      // Reset during SUB discards the round; a fresh request still completes.
      start(rand128(), rand128(), 1'b0, "midreset");
      repeat (7) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("midreset in_ready", 128'(in_ready), 128'(1));
      check("midreset out_valid", 128'(out_valid), 128'(0));
      check("midreset busy", 128'(busy), 128'(0));
      check("midreset state_out", state_out, 128'(0));
      run_round(rand128(), rand128(), 1'b0, "after reset", res);

      // Random rounds of both kinds.
      for (int i = 0; i < 24; i++) begin
         run_round(rand128(), rand128(), 1'($urandom_range(0, 1)), "random", res);
      end

      // Streaming with out_ready tied high and in_valid held.
      back_to_back(1'b0, 5, "b2b full");
      back_to_back(1'b1, 5, "b2b final");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
